// File: rtl/rb_pkg.sv
// Shared definitions for the row-buffer window controller.
//   - BRAM geometry of the asymmetric row buffer: port A is 8-bit write and
//     byte-addressed; port B is 32-bit read and word-addressed.
//   - Controller state encoding.
package rb_pkg;

    localparam int ADDR_A_W       = 11;
    localparam int ADDR_B_W       = 9;
    localparam int DIN_A_W        = 8;
    localparam int DOUT_B_W       = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic {
        ACCEPT = 1'b0,
        READ   = 1'b1
    } rb_state_t;

endpackage

// File: rtl/rb_addr_gen.sv
// Row-slot / column bookkeeping and BRAM address arithmetic.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr          restart at column 0, slot 0, no completed rows
//   adv          one pixel accepted: advance column, wrap row and slot
//   latch        capture word column and slot of the pixel being accepted
//   tap          tap index whose word address is wanted
//   byte_addr    port A address of the pixel at the current column
//   word_addr    port B address of the latched word column for 'tap'
//   word_col     latched word column
//   word_done    current pixel ends a word and enough rows exist to emit
module rb_addr_gen
    import rb_pkg::*;
#(
    parameter int IMG_WIDTH = 512,
    parameter int NUM_SLOTS = 4,
    parameter int WIN_ROWS  = 3,
    parameter int COL_W     = $clog2(IMG_WIDTH / 4),
    parameter int TAP_W     = $clog2(WIN_ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                adv,
    input  logic                latch,
    input  logic [TAP_W-1:0]    tap,
    output logic [ADDR_A_W-1:0] byte_addr,
    output logic [ADDR_B_W-1:0] word_addr,
    output logic [COL_W-1:0]    word_col,
    output logic                word_done
);

    localparam int PCOL_W        = $clog2(IMG_WIDTH);
    localparam int SLOT_W        = $clog2(NUM_SLOTS);
    localparam int WORDS_PER_ROW = IMG_WIDTH / BYTES_PER_WORD;
    localparam int NTAB          = 2 ** TAP_W;

    logic [PCOL_W-1:0] col_reg;
    logic [SLOT_W-1:0] cur_slot_reg;
    logic [SLOT_W-1:0] lat_slot_reg;
    logic [TAP_W-1:0]  rows_done_reg;
    logic [COL_W-1:0]  wc_reg;

    logic row_end;
    assign row_end = (col_reg == PCOL_W'(IMG_WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg       <= '0;
            cur_slot_reg  <= '0;
            lat_slot_reg  <= '0;
            rows_done_reg <= '0;
            wc_reg        <= '0;
        end else if (clr) begin
            col_reg       <= '0;
            cur_slot_reg  <= '0;
            rows_done_reg <= '0;
        end else begin
            if (latch) begin
                wc_reg       <= col_reg[PCOL_W-1:2];
                lat_slot_reg <= cur_slot_reg;
            end
            if (adv) begin
                if (row_end) begin
                    col_reg      <= '0;
                    cur_slot_reg <= (cur_slot_reg == SLOT_W'(NUM_SLOTS - 1))
                                    ? '0 : cur_slot_reg + SLOT_W'(1);
                    if (rows_done_reg != TAP_W'(WIN_ROWS - 1))
                        rows_done_reg <= rows_done_reg + TAP_W'(1);
                end else begin
                    col_reg <= col_reg + PCOL_W'(1);
                end
            end
        end
    end

    // Decision uses the row count before this pixel's row-end update.
    assign word_done = (col_reg[1:0] == 2'b11) &&
                       (rows_done_reg == TAP_W'(WIN_ROWS - 1));

    assign byte_addr = ADDR_A_W'(cur_slot_reg) * ADDR_A_W'(IMG_WIDTH)
                     + ADDR_A_W'(col_reg);

    // Slot of tap k is (s - WIN_ROWS + 1 + k) mod NUM_SLOTS. The biased sum
    // stays below 2*NUM_SLOTS for real taps, so one conditional subtract
    // performs the wrap. The table is padded to a power of two so any tap
    // code indexes a defined entry.
    logic [SLOT_W-1:0] tap_slot [NTAB];

    genvar gi;
    generate
        for (gi = 0; gi < NTAB; gi++) begin : g_tap_slot
            logic [SLOT_W:0] sum;
            assign sum = {1'b0, lat_slot_reg}
                       + (SLOT_W+1)'(NUM_SLOTS - WIN_ROWS + 1 + gi);
            assign tap_slot[gi] = (sum >= (SLOT_W+1)'(NUM_SLOTS))
                                ? SLOT_W'(sum - (SLOT_W+1)'(NUM_SLOTS))
                                : SLOT_W'(sum);
        end
    endgenerate

    assign word_addr = ADDR_B_W'(tap_slot[tap]) * ADDR_B_W'(WORDS_PER_ROW)
                     + ADDR_B_W'(wc_reg);
    assign word_col  = wc_reg;

endmodule

// File: rtl/rb_window_ctrl.sv
// Row-buffer window controller. Writes a raster pixel stream into a circular
// set of row slots through BRAM port A and, after each completed 4-pixel
// word, reads the co-located word of the WIN_ROWS most recent rows through
// port B and streams them out oldest row first.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   frame_start              synchronous restart of the frame
//   in_valid/in_ready/in_pixel    pixel input handshake
//   mem_en_a/mem_w_a/mem_addr_a/mem_din_a   BRAM port A (byte write)
//   mem_en_b/mem_addr_b/mem_dout_b          BRAM port B (word read, 1-cycle)
//   out_valid/out_ready/out_data/out_col/out_tap   tap word output
//   busy                     tap read sequence in progress
module rb_window_ctrl
    import rb_pkg::*;
#(
    parameter int IMG_WIDTH = 512,
    parameter int NUM_SLOTS = 4,
    parameter int WIN_ROWS  = 3,
    parameter int COL_W     = $clog2(IMG_WIDTH / 4),
    parameter int TAP_W     = $clog2(WIN_ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DIN_A_W-1:0]  in_pixel,
    output logic                mem_en_a,
    output logic                mem_w_a,
    output logic [ADDR_A_W-1:0] mem_addr_a,
    output logic [DIN_A_W-1:0]  mem_din_a,
    output logic                mem_en_b,
    output logic [ADDR_B_W-1:0] mem_addr_b,
    input  logic [DOUT_B_W-1:0] mem_dout_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DOUT_B_W-1:0] out_data,
    output logic [COL_W-1:0]    out_col,
    output logic [TAP_W-1:0]    out_tap,
    output logic                busy
);

    rb_state_t state_reg, state_next;

    logic                in_ready_reg,   in_ready_next;
    logic                mem_wr_reg,     mem_wr_next;
    logic [ADDR_A_W-1:0] mem_addr_a_reg, mem_addr_a_next;
    logic [DIN_A_W-1:0]  mem_din_a_reg,  mem_din_a_next;
    logic                mem_en_b_reg,   mem_en_b_next;
    logic [ADDR_B_W-1:0] mem_addr_b_reg, mem_addr_b_next;
    logic                out_valid_reg,  out_valid_next;
    logic [DOUT_B_W-1:0] out_data_reg,   out_data_next;
    logic [COL_W-1:0]    out_col_reg,    out_col_next;
    logic [TAP_W-1:0]    out_tap_reg,    out_tap_next;
    logic                busy_reg,       busy_next;
    // rd_wait: port B data is valid this cycle and is captured at its end.
    logic                rd_wait_reg,    rd_wait_next;
    logic [TAP_W-1:0]    iss_tap_reg,    iss_tap_next;
    logic                iss_done_reg,   iss_done_next;
    logic [TAP_W-1:0]    rd_tap_reg,     rd_tap_next;

    logic                gen_clr, gen_adv, gen_latch;
    logic [ADDR_A_W-1:0] byte_addr;
    logic [ADDR_B_W-1:0] word_addr;
    logic [COL_W-1:0]    word_col;
    logic                word_done;

    rb_addr_gen #(
        .IMG_WIDTH (IMG_WIDTH),
        .NUM_SLOTS (NUM_SLOTS),
        .WIN_ROWS  (WIN_ROWS),
        .COL_W     (COL_W),
        .TAP_W     (TAP_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (gen_clr),
        .adv       (gen_adv),
        .latch     (gen_latch),
        .tap       (iss_tap_reg),
        .byte_addr (byte_addr),
        .word_addr (word_addr),
        .word_col  (word_col),
        .word_done (word_done)
    );

    always_comb begin
        state_next      = state_reg;
        in_ready_next   = in_ready_reg;
        mem_wr_next     = 1'b0;
        mem_addr_a_next = mem_addr_a_reg;
        mem_din_a_next  = mem_din_a_reg;
        mem_en_b_next   = 1'b0;
        mem_addr_b_next = mem_addr_b_reg;
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_col_next    = out_col_reg;
        out_tap_next    = out_tap_reg;
        busy_next       = busy_reg;
        rd_wait_next    = mem_en_b_reg;
        iss_tap_next    = iss_tap_reg;
        iss_done_next   = iss_done_reg;
        rd_tap_next     = rd_tap_reg;
        gen_clr         = 1'b0;
        gen_adv         = 1'b0;
        gen_latch       = 1'b0;

        if (frame_start) begin
            // Restart wins over pixel input and any read activity; a read
            // still in flight is dropped by clearing rd_wait.
            state_next     = ACCEPT;
            in_ready_next  = 1'b1;
            out_valid_next = 1'b0;
            busy_next      = 1'b0;
            rd_wait_next   = 1'b0;
            gen_clr        = 1'b1;
        end else begin
            case (state_reg)
                ACCEPT: begin
                    in_ready_next = 1'b1;
                    busy_next     = 1'b0;
                    if (in_valid && in_ready_reg) begin
                        gen_adv         = 1'b1;
                        mem_wr_next     = 1'b1;
                        mem_addr_a_next = byte_addr;
                        mem_din_a_next  = in_pixel;
                        if (word_done) begin
                            gen_latch     = 1'b1;
                            state_next    = READ;
                            in_ready_next = 1'b0;
                            busy_next     = 1'b1;
                            iss_tap_next  = '0;
                            iss_done_next = 1'b0;
                        end
                    end
                end
                READ: begin
                    if (out_valid_reg && out_ready) begin
                        out_valid_next = 1'b0;
                        if (out_tap_reg == TAP_W'(WIN_ROWS - 1)) begin
                            state_next    = ACCEPT;
                            in_ready_next = 1'b1;
                            busy_next     = 1'b0;
                        end
                    end
                    if (rd_wait_reg) begin
                        out_data_next  = mem_dout_b;
                        out_col_next   = word_col;
                        out_tap_next   = rd_tap_reg;
                        out_valid_next = 1'b1;
                    end
                    // One read at a time, only when the output slot is free
                    // (or being freed this cycle). The current-row tap goes
                    // last, well after its port A write strobe.
                    if (!iss_done_reg && !mem_en_b_reg && !rd_wait_reg &&
                        (!out_valid_reg || out_ready)) begin
                        mem_en_b_next   = 1'b1;
                        mem_addr_b_next = word_addr;
                        rd_tap_next     = iss_tap_reg;
                        if (iss_tap_reg == TAP_W'(WIN_ROWS - 1))
                            iss_done_next = 1'b1;
                        else
                            iss_tap_next = iss_tap_reg + TAP_W'(1);
                    end
                end
                default: state_next = ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ACCEPT;
            in_ready_reg   <= 1'b0;
            mem_wr_reg     <= 1'b0;
            mem_addr_a_reg <= '0;
            mem_din_a_reg  <= '0;
            mem_en_b_reg   <= 1'b0;
            mem_addr_b_reg <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_col_reg    <= '0;
            out_tap_reg    <= '0;
            busy_reg       <= 1'b0;
            rd_wait_reg    <= 1'b0;
            iss_tap_reg    <= '0;
            iss_done_reg   <= 1'b0;
            rd_tap_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            in_ready_reg   <= in_ready_next;
            mem_wr_reg     <= mem_wr_next;
            mem_addr_a_reg <= mem_addr_a_next;
            mem_din_a_reg  <= mem_din_a_next;
            mem_en_b_reg   <= mem_en_b_next;
            mem_addr_b_reg <= mem_addr_b_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_col_reg    <= out_col_next;
            out_tap_reg    <= out_tap_next;
            busy_reg       <= busy_next;
            rd_wait_reg    <= rd_wait_next;
            iss_tap_reg    <= iss_tap_next;
            iss_done_reg   <= iss_done_next;
            rd_tap_reg     <= rd_tap_next;
        end
    end

    assign in_ready   = in_ready_reg;
    assign mem_en_a   = mem_wr_reg;
    assign mem_w_a    = mem_wr_reg;
    assign mem_addr_a = mem_addr_a_reg;
    assign mem_din_a  = mem_din_a_reg;
    assign mem_en_b   = mem_en_b_reg;
    assign mem_addr_b = mem_addr_b_reg;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_col    = out_col_reg;
    assign out_tap    = out_tap_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_rb_window_ctrl.sv
// Bench for rb_window_ctrl with an 8-pixel-wide image, 4 slots, 3-row window
// and a behavioural model of the asymmetric BRAM. Pixel value = running
// index (restarting after frame_start / rst).
module tb_rb_window_ctrl;

    localparam int IMG_WIDTH = 8;
    localparam int NUM_SLOTS = 4;
    localparam int WIN_ROWS  = 3;
    localparam int COL_W     = 1;
    localparam int TAP_W     = 2;
    localparam int N_EXP     = 25;

    logic        clk, rst, frame_start;
    logic        in_valid, in_ready;
    logic [7:0]  in_pixel;
    logic        mem_en_a, mem_w_a;
    logic [10:0] mem_addr_a;
    logic [7:0]  mem_din_a;
    logic        mem_en_b;
    logic [8:0]  mem_addr_b;
    logic [31:0] mem_dout_b;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [COL_W-1:0] out_col;
    logic [TAP_W-1:0] out_tap;
    logic        busy;

    rb_window_ctrl #(
        .IMG_WIDTH (IMG_WIDTH),
        .NUM_SLOTS (NUM_SLOTS),
        .WIN_ROWS  (WIN_ROWS),
        .COL_W     (COL_W),
        .TAP_W     (TAP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pixel    (in_pixel),
        .mem_en_a    (mem_en_a),
        .mem_w_a     (mem_w_a),
        .mem_addr_a  (mem_addr_a),
        .mem_din_a   (mem_din_a),
        .mem_en_b    (mem_en_b),
        .mem_addr_b  (mem_addr_b),
        .mem_dout_b  (mem_dout_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_col     (out_col),
        .out_tap     (out_tap),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: byte write on A, little-endian word read on B, 1-cycle latency.
    logic [7:0] mem [2048];
    initial mem_dout_b = '0;
    always @(posedge clk) begin
        if (mem_en_a && mem_w_a) mem[mem_addr_a] <= mem_din_a;
        if (mem_en_b) mem_dout_b <= {mem[{mem_addr_b, 2'd3}], mem[{mem_addr_b, 2'd2}],
                                     mem[{mem_addr_b, 2'd1}], mem[{mem_addr_b, 2'd0}]};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {stimulus: accepted-pixel count at handshake, expected tap outputs}
    typedef struct {
        logic [31:0]      data;
        logic [COL_W-1:0] col;
        logic [TAP_W-1:0] tap;
        int               acc;
    } tap_rec_t;

    tap_rec_t got_q[$];
    tap_rec_t exp_tab [N_EXP];
    int       acc_cnt = 0;
    int       a_idx = 0;
    bit       seen_valid = 0;

    // Monitor, sampled mid-cycle: port A stream and tap handshakes.
    always @(negedge clk) begin
        if (rst || frame_start) begin
            acc_cnt = 0;
            a_idx   = 0;
            if (rst) seen_valid = 0;
        end else begin
            if (mem_en_a) begin
                chk("wr_strobe", {63'd0, mem_w_a}, 64'd1);
                chk("addr_a", {53'd0, mem_addr_a}, 64'(a_idx % (IMG_WIDTH * NUM_SLOTS)));
                chk("din_a", {56'd0, mem_din_a}, 64'(a_idx % 256));
                a_idx++;
            end
            if (mem_en_b) chk("en_b_out_busy", {63'd0, out_valid}, 64'd0);
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid) seen_valid = 1;
            if (out_valid && out_ready) begin
                tap_rec_t r;
                r.data = out_data; r.col = out_col; r.tap = out_tap; r.acc = acc_cnt;
                got_q.push_back(r);
            end
        end
    end

    task automatic push(input logic [7:0] v);
        bit got;
        int n;
        in_valid = 1'b1;
        in_pixel = v;
        n = 0;
        got = 0;
        while (!got && n <= 100) begin
            got = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL push_timeout: pixel 0x%0h not accepted within 100 cycles", v);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(!busy && in_ready) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL %s: controller did not return to idle within 200 cycles", name);
        end
    endtask

    task automatic wait_tap1(input string name);
        int n = 0;
        while (!(out_valid && out_tap == 2'd1) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL %s: tap 1 not presented within 200 cycles", name);
        end
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_ctl"}, {58'd0, in_ready, mem_en_a, mem_w_a, mem_en_b, out_valid, busy}, 64'd0);
        chk({name, "_addr"}, {36'd0, mem_addr_a, mem_din_a, mem_addr_b}, 64'd0);
        chk({name, "_out"}, {29'd0, out_data, out_col, out_tap}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Rows 2..4, both word columns, out_ready held high.
        exp_tab[0]  = '{32'h03020100, 1'b0, 2'd0, 20};
        exp_tab[1]  = '{32'h0B0A0908, 1'b0, 2'd1, 20};
        exp_tab[2]  = '{32'h13121110, 1'b0, 2'd2, 20};
        exp_tab[3]  = '{32'h07060504, 1'b1, 2'd0, 24};
        exp_tab[4]  = '{32'h0F0E0D0C, 1'b1, 2'd1, 24};
        exp_tab[5]  = '{32'h17161514, 1'b1, 2'd2, 24};
        exp_tab[6]  = '{32'h0B0A0908, 1'b0, 2'd0, 28};
        exp_tab[7]  = '{32'h13121110, 1'b0, 2'd1, 28};
        exp_tab[8]  = '{32'h1B1A1918, 1'b0, 2'd2, 28};
        exp_tab[9]  = '{32'h0F0E0D0C, 1'b1, 2'd0, 32};
        exp_tab[10] = '{32'h17161514, 1'b1, 2'd1, 32};
        exp_tab[11] = '{32'h1F1E1D1C, 1'b1, 2'd2, 32};
        exp_tab[12] = '{32'h13121110, 1'b0, 2'd0, 36};
        exp_tab[13] = '{32'h1B1A1918, 1'b0, 2'd1, 36};
        exp_tab[14] = '{32'h23222120, 1'b0, 2'd2, 36};
        exp_tab[15] = '{32'h17161514, 1'b1, 2'd0, 40};
        exp_tab[16] = '{32'h1F1E1D1C, 1'b1, 2'd1, 40};
        exp_tab[17] = '{32'h27262524, 1'b1, 2'd2, 40};
        // Row 5 word 0 with back-pressure on tap 1.
        exp_tab[18] = '{32'h1B1A1918, 1'b0, 2'd0, 44};
        exp_tab[19] = '{32'h23222120, 1'b0, 2'd1, 44};
        exp_tab[20] = '{32'h2B2A2928, 1'b0, 2'd2, 44};
        // Row 5 word 1: only tap 0 completes before frame_start.
        exp_tab[21] = '{32'h1F1E1D1C, 1'b1, 2'd0, 48};
        // New frame: first word of row 2 again.
        exp_tab[22] = '{32'h03020100, 1'b0, 2'd0, 20};
        exp_tab[23] = '{32'h0B0A0908, 1'b0, 2'd1, 20};
        exp_tab[24] = '{32'h13121110, 1'b0, 2'd2, 20};

        rst = 1'b1; frame_start = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b0;
        #1;
        chk("in_ready_at_release", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("in_ready_rise", {63'd0, in_ready}, 64'd1);

        // Rows 0-1: writes only, no taps.
        for (int p = 0; p < 16; p++) push(8'(p));
        repeat (4) @(posedge clk);
        #1;
        chk("s1_no_out_valid", {63'd0, seen_valid}, 64'd0);
        chk("s1_busy", {63'd0, busy}, 64'd0);
        $display("scenario 1: rows 0-1 written");

        // Rows 2-4 including slot wrap.
        for (int p = 16; p < 40; p++) push(8'(p));
        wait_idle("s3_idle");
        $display("scenario 2/3: rows 2-4 streamed, %0d taps seen", got_q.size());

        // Back-pressure during tap 1.
        for (int p = 40; p < 44; p++) push(8'(p));
        wait_tap1("s4_tap1");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("s4_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("s4_hold_data", {32'd0, out_data}, 64'h23222120);
            chk("s4_hold_col", {63'd0, out_col}, 64'd0);
            chk("s4_hold_tap", {62'd0, out_tap}, 64'd1);
            chk("s4_hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("s4_hold_en_b", {63'd0, mem_en_b}, 64'd0);
        end
        out_ready = 1'b1;
        wait_idle("s4_idle");
        $display("scenario 4: back-pressure released, %0d taps seen", got_q.size());

        // frame_start during tap 1.
        for (int p = 44; p < 48; p++) push(8'(p));
        wait_tap1("s5_tap1");
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("s5_out_valid", {63'd0, out_valid}, 64'd0);
        chk("s5_busy", {63'd0, busy}, 64'd0);
        chk("s5_in_ready", {63'd0, in_ready}, 64'd1);
        chk("s5_en_b", {63'd0, mem_en_b}, 64'd0);
        for (int p = 0; p < 20; p++) push(8'(p));
        wait_idle("s5_idle");
        repeat (4) @(posedge clk);
        #1;
        $display("scenario 5: frame restarted, %0d taps seen", got_q.size());

        // Reset mid-row.
        for (int p = 20; p < 23; p++) push(8'(p));
        rst = 1'b1;
        #1;
        chk_reset_outs("s6_rst_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk_reset_outs("s6_rst_held");
        end
        rst = 1'b0;
        #1;
        chk("s6_in_ready_at_release", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("s6_in_ready_rise", {63'd0, in_ready}, 64'd1);
        for (int p = 0; p < 16; p++) push(8'(p));
        repeat (4) @(posedge clk);
        #1;
        chk("s6_no_out_valid", {63'd0, seen_valid}, 64'd0);
        chk("s6_busy", {63'd0, busy}, 64'd0);
        $display("scenario 6: restart after reset, rows 0-1 written");

        // Tap stream against the expected table.
        chk("tap_count", 64'(got_q.size()), 64'(N_EXP));
        for (int i = 0; i < N_EXP && i < got_q.size(); i++) begin
            chk($sformatf("tap%0d_data", i), {32'd0, got_q[i].data}, {32'd0, exp_tab[i].data});
            chk($sformatf("tap%0d_col", i), {63'd0, got_q[i].col}, {63'd0, exp_tab[i].col});
            chk($sformatf("tap%0d_tap", i), {62'd0, got_q[i].tap}, {62'd0, exp_tab[i].tap});
            chk($sformatf("tap%0d_acc", i), 64'(got_q[i].acc), 64'(exp_tab[i].acc));
            $display("tap %0d: data=0x%08h col=%0d tap=%0d after %0d pixels",
                     i, got_q[i].data, got_q[i].col, got_q[i].tap, got_q[i].acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
